divider_32bit: RTL and testbench

- Sequential restoring integer divider.
- Inverse companion of the team's shift-add multiplier: same start/done handshake style, one quotient bit per clock.
- Sits beside the multiplier as a shared arithmetic utility for the RISC-V core's M-extension (DIV/DIVU/REM/REMU) and for accelerator address/scale computations.
- Fully synchronous to one clock; asynchronous active-low reset.

---
 rtl/divider_32bit.sv | 171 +++++++++++++++++
 tb/tb_divider_32bit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/divider_32bit.sv
`default_nettype none
// ============================================================================
//  Module   : divider_32bit
//  Purpose  : Sequential restoring integer divider. Produces one quotient bit
//             per clock using a start/done handshake. Results follow RISC-V
//             M-extension semantics for divide-by-zero and signed overflow.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk          system clock, rising edge
//    rst_n        asynchronous reset, active low
//    start        request, sampled only while idle
//    dividend     numerator, captured on the accepting edge
//    divisor      denominator, captured on the accepting edge
//    signed_op    signed select (only meaningful with DIV_SIGNED_EN)
//    quotient     registered quotient
//    remainder    registered remainder
//    busy         operation in progress
//    done         one-cycle pulse when results are valid
//    div_by_zero  last operation had a zero divisor
//
//  Build option
//    DIV_SIGNED_EN  when defined, signed_op=1 selects two's-complement
//                   division (magnitude divide plus sign fix-up in FINISH).
// ============================================================================
module divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] part_rem;      // partial remainder
  logic [WIDTH-1:0] shift_reg;     // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] divisor_reg;   // divisor magnitude
  logic [WIDTH-1:0] dividend_reg;  // original dividend, returned on divide-by-zero

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // One extra bit so the shifted partial remainder can exceed 2^WIDTH-1
  // without losing the carry; a clear top bit of diff means trial >= divisor.
  always_comb begin
    trial = {part_rem, shift_reg[WIDTH-1]};
    diff  = trial - {1'b0, divisor_reg};
  end

`ifdef DIV_SIGNED_EN
  logic neg_quot;
  logic neg_rem;
  logic dividend_neg;
  logic divisor_neg;

  always_comb begin
    dividend_neg = signed_op & dividend[WIDTH-1];
    divisor_neg  = signed_op & divisor[WIDTH-1];
    dividend_mag = dividend_neg ? -dividend : dividend;
    divisor_mag  = divisor_neg  ? -divisor  : divisor;
    // Most-negative / -1 falls out naturally: magnitude 2^(W-1) / 1 with no
    // quotient negation yields the most-negative value and a zero remainder.
    quot_fix     = neg_quot ? -shift_reg : shift_reg;
    rem_fix      = neg_rem  ? -part_rem  : part_rem;
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;

  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    quot_fix     = shift_reg;
    rem_fix      = part_rem;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      part_rem     <= '0;
      shift_reg    <= '0;
      divisor_reg  <= '0;
      dividend_reg <= '0;
      quotient     <= '0;
      remainder    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot     <= 1'b0;
      neg_rem      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor_mag;
            shift_reg    <= dividend_mag;
            part_rem     <= '0;
            count        <= CW'(WIDTH - 1);
            busy         <= 1'b1;
            div_by_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot     <= dividend_neg ^ divisor_neg;
            neg_rem      <= dividend_neg;
`endif
            state        <= (divisor == '0) ? FINISH : RUN;
          end
        end

        RUN: begin
          if (!diff[WIDTH]) begin
            part_rem  <= diff[WIDTH-1:0];
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b1};
          end else begin
            part_rem  <= trial[WIDTH-1:0];
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          end
          if (count == '0) begin
            state <= FINISH;
          end else begin
            count <= count - CW'(1);
          end
        end

        FINISH: begin
          if (divisor_reg == '0) begin
            quotient    <= '1;
            remainder   <= dividend_reg;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= quot_fix;
            remainder   <= rem_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_32bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider_32bit
//  Purpose  : Self-checking bench for divider_32bit. Expected results are
//             queued when an operation is launched and compared when done
//             pulses, including the cycle on which done appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_divider_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        signed_op;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  divider_32bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_op   (signed_op),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Result monitor: compares on done, and checks busy while an op is in flight.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
          check("done_latency", cyc, e.at);
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end else if (sb.size() != 0) begin
        check("busy_in_flight", 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 120 && sb.size() != 0; i++) @(negedge clk);
    check("timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    exp_t e;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    e.at = cyc + ((b == 32'd0) ? 1 : 33);
    sb.push_back(e);
    start = 1'b0;
    wait_empty();
  endtask

  initial begin
    exp_t e;
    int unsigned acc;
    logic [31:0] a, b;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    // Basic and extreme operands
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(32'd5, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd5, 1'b0);
    run_op(32'd0, 32'd9, 1'b0, 32'd0, 32'd0, 1'b0);

    // Divide by zero, then a normal op clears the flag
    run_op(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

    // Start re-asserted mid-operation is ignored; held start is accepted
    // on the first idle edge after done.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    e.q = 32'd14; e.r = 32'd2; e.dz = 1'b0; e.at = acc + 33;
    sb.push_back(e);
    start = 1'b0;
    repeat (10) @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    e.q = 32'd10; e.r = 32'd0; e.dz = 1'b0; e.at = acc + 67;
    sb.push_back(e);
    for (int i = 0; i < 60 && sb.size() > 1; i++) @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("q_held_after_accept", quotient, 32'd14);
    wait_empty();

    // Reset mid-operation aborts without a done pulse
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);

    // Random unsigned operations against the language's own division
    for (int i = 0; i < 6; i++) begin
      a = $urandom();
      b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom();
      if (b == 32'd0) b = 32'd1;
      run_op(a, b, 1'b0, a / b, a % b, 1'b0);
    end

`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
`else
    // signed_op has no effect in the unsigned build
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
